// File: rtl/hs_rr_scheduler_pkg.sv
// Shared types and helpers for the async_lib handshake schedulers.
// Holds the handshake FSM state encoding and the modulo pointer increment.
package async_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        ACK  = 2'd2,
        REL  = 2'd3
    } hs_state_t;

    // Explicit wrap so non-power-of-two requester counts rotate correctly.
    function automatic int unsigned rr_next(input int unsigned ptr, input int unsigned n);
        if (ptr + 32'd1 >= n) begin
            return 32'd0;
        end else begin
            return ptr + 32'd1;
        end
    endfunction

endpackage

// File: rtl/hs_rr_scheduler_rr_pick.sv
// Combinational rotating priority encoder: first set request at or after i_ptr.
// Reusable by any scheduler needing round-robin selection.
module rr_pick #(
    parameter int N  = 8,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_ptr,
    output logic          o_valid,
    output logic [IW-1:0] o_idx
);

    logic [2*N-1:0] w_dbl;
    logic [N-1:0]   w_rot;
    logic [IW:0]    w_off;
    logic [IW:0]    w_sum;

    // Rotate so the pointer position lands at bit 0, then take the lowest set bit.
    always_comb begin
        w_dbl   = {i_req, i_req} >> i_ptr;
        w_rot   = w_dbl[N-1:0];
        w_off   = '0;
        o_valid = |i_req;
        for (int k = N - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                w_off = (IW+1)'(k);
            end else begin
                w_off = w_off;
            end
        end
        w_sum = {1'b0, i_ptr} + w_off;
        if (w_sum >= (IW+1)'(N)) begin
            w_sum = w_sum - (IW+1)'(N);
        end else begin
            w_sum = w_sum;
        end
        o_idx = w_sum[IW-1:0];
    end

endmodule

// File: rtl/hs_rr_scheduler.sv
// Round-robin scheduler sharing one 4-phase req/ack channel among NUM_REQ requesters.
// Optional macro HS_SYNC_INPUTS_EN adds 2-flop synchronizers on req_in and ack_out.
module hs_rr_scheduler
    import async_pkg::*;
#(
    parameter  int NUM_REQ = 8,
    localparam int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req_in,
    output logic [NUM_REQ-1:0] ack_in,
    output logic               req_out,
    input  logic               ack_out,
    output logic [IDX_W-1:0]   grant_idx,
    output logic               busy
);

    logic [NUM_REQ-1:0] w_req;
    logic               w_ack;

`ifdef HS_SYNC_INPUTS_EN
    logic [NUM_REQ-1:0] r_req_meta;
    logic [NUM_REQ-1:0] r_req_sync;
    logic               r_ack_meta;
    logic               r_ack_sync;

    // Two-stage synchronizers for the asynchronous handshake inputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_req_meta <= '0;
            r_req_sync <= '0;
            r_ack_meta <= 1'b0;
            r_ack_sync <= 1'b0;
        end else begin
            r_req_meta <= req_in;
            r_req_sync <= r_req_meta;
            r_ack_meta <= ack_out;
            r_ack_sync <= r_ack_meta;
        end
    end

    assign w_req = r_req_sync;
    assign w_ack = r_ack_sync;
`else
    assign w_req = req_in;
    assign w_ack = ack_out;
`endif

    hs_state_t          r_state;
    hs_state_t          w_state_nxt;
    logic [NUM_REQ-1:0] r_ack_in;
    logic [NUM_REQ-1:0] w_ack_in_nxt;
    logic [NUM_REQ-1:0] w_onehot;
    logic               r_req_out;
    logic               w_req_out_nxt;
    logic [IDX_W-1:0]   r_grant_idx;
    logic [IDX_W-1:0]   w_grant_nxt;
    logic [IDX_W-1:0]   r_rr_ptr;
    logic [IDX_W-1:0]   w_ptr_nxt;
    logic               r_busy;
    logic               w_busy_nxt;
    logic               w_pick_valid;
    logic [IDX_W-1:0]   w_pick_idx;

    rr_pick #(.N(NUM_REQ), .IW(IDX_W)) u_pick (
        .i_req   (w_req),
        .i_ptr   (r_rr_ptr),
        .o_valid (w_pick_valid),
        .o_idx   (w_pick_idx)
    );

    // Next-state and next-output logic for the handshake FSM.
    always_comb begin
        w_state_nxt   = r_state;
        w_ack_in_nxt  = r_ack_in;
        w_req_out_nxt = r_req_out;
        w_grant_nxt   = r_grant_idx;
        w_ptr_nxt     = r_rr_ptr;
        w_onehot      = '0;
        w_onehot[r_grant_idx] = 1'b1;
        case (r_state)
            IDLE: begin
                // A stuck ack_out from the shared side blocks new grants until it clears.
                if (!w_ack && w_pick_valid) begin
                    w_state_nxt   = REQ;
                    w_grant_nxt   = w_pick_idx;
                    w_req_out_nxt = 1'b1;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            REQ: begin
                if (w_ack) begin
                    w_state_nxt  = ACK;
                    w_ack_in_nxt = w_onehot;
                end else begin
                    w_state_nxt = REQ;
                end
            end
            ACK: begin
                if (!w_req[r_grant_idx]) begin
                    w_state_nxt   = REL;
                    w_req_out_nxt = 1'b0;
                end else begin
                    w_state_nxt = ACK;
                end
            end
            REL: begin
                if (!w_ack) begin
                    w_state_nxt  = IDLE;
                    w_ack_in_nxt = '0;
                    w_ptr_nxt    = IDX_W'(rr_next(32'(r_grant_idx), 32'(NUM_REQ)));
                end else begin
                    w_state_nxt = REL;
                end
            end
            default: begin
                w_state_nxt   = IDLE;
                w_ack_in_nxt  = '0;
                w_req_out_nxt = 1'b0;
            end
        endcase
        w_busy_nxt = (w_state_nxt != IDLE);
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_ack_in    <= '0;
            r_req_out   <= 1'b0;
            r_grant_idx <= '0;
            r_rr_ptr    <= '0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_ack_in    <= w_ack_in_nxt;
            r_req_out   <= w_req_out_nxt;
            r_grant_idx <= w_grant_nxt;
            r_rr_ptr    <= w_ptr_nxt;
            r_busy      <= w_busy_nxt;
        end
    end

    assign ack_in    = r_ack_in;
    assign req_out   = r_req_out;
    assign grant_idx = r_grant_idx;
    assign busy      = r_busy;

endmodule

// File: tb/tb_hs_rr_scheduler.sv
// Directed self-checking bench for hs_rr_scheduler with NUM_REQ=4 (default build).
// Expected grants come from a bench-side round-robin model through a scoreboard queue.
module tb_hs_rr_scheduler;

    localparam int N = 4;

    logic         clk;
    logic         rst_n;
    logic [N-1:0] req_in;
    logic [N-1:0] ack_in;
    logic         req_out;
    logic         ack_out;
    logic [1:0]   grant_idx;
    logic         busy;

    int n_checks;
    int n_errors;
    int m_ptr;
    int cur_g;
    int sb_q[$];

    hs_rr_scheduler #(.NUM_REQ(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_in    (req_in),
        .ack_in    (ack_in),
        .req_out   (req_out),
        .ack_out   (ack_out),
        .grant_idx (grant_idx),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int model_pick(input logic [N-1:0] v, input int ptr);
        int c;
        for (int k = 0; k < N; k++) begin
            c = (ptr + k) % N;
            if (v[c]) return c;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] onehot(input int g);
        logic [N-1:0] r;
        r = '0;
        r[g] = 1'b1;
        return r;
    endfunction

    // Drive a request vector from IDLE and expect a grant one edge later.
    task automatic issue(input logic [N-1:0] v);
        req_in = v;
        sb_q.push_back(model_pick(v, m_ptr));
        tick();
        chk("req_out_latency", 32'(req_out), 32'd1);
        chk("busy_on_grant", 32'(busy), 32'd1);
        if (sb_q.size() == 0) begin
            chk("sb_empty", 32'd1, 32'd0);
            cur_g = 0;
        end else begin
            cur_g = sb_q.pop_front();
            chk("grant_idx", 32'(grant_idx), 32'(cur_g));
        end
    endtask

    // Finish the 4-phase handshake of the current grant; optionally re-raise its request.
    task automatic complete(input logic rearm);
        ack_out = 1'b1;
        tick();
        chk("ack_in_set", 32'(ack_in), 32'(onehot(cur_g)));
        chk("req_out_hold", 32'(req_out), 32'd1);
        req_in[cur_g] = 1'b0;
        tick();
        chk("req_out_drop", 32'(req_out), 32'd0);
        chk("ack_in_hold", 32'(ack_in), 32'(onehot(cur_g)));
        chk("busy_rel", 32'(busy), 32'd1);
        ack_out = 1'b0;
        tick();
        chk("ack_in_clear", 32'(ack_in), 32'd0);
        chk("busy_idle", 32'(busy), 32'd0);
        chk("grant_hold", 32'(grant_idx), 32'(cur_g));
        m_ptr = (cur_g + 1) % N;
        if (rearm) req_in[cur_g] = 1'b1;
    endtask

    task automatic do_reset();
        rst_n   = 1'b0;
        req_in  = '0;
        ack_out = 1'b0;
        m_ptr   = 0;
        sb_q.delete();
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        int order[5];
        order    = '{0, 1, 2, 3, 0};
        n_checks = 0;
        n_errors = 0;
        cur_g    = 0;
        rst_n    = 1'b0;
        req_in   = '0;
        ack_out  = 1'b0;
        m_ptr    = 0;
        tick();
        chk("rst_ack_in", 32'(ack_in), 32'd0);
        chk("rst_req_out", 32'(req_out), 32'd0);
        chk("rst_grant", 32'(grant_idx), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        tick();
        chk("idle_req_out", 32'(req_out), 32'd0);

        // Single request on index 1; pointer then moves to 2.
        issue(4'b0010);
        complete(1'b0);
        // Pointer at 2 must prefer index 2 over 0.
        issue(4'b0101);
        chk("ptr2_grant", 32'(grant_idx), 32'd2);
        req_in[0] = 1'b0;
        complete(1'b0);
        // Pointer at 3 with only bit 0 set: wraps to 0, pointer becomes 1.
        issue(4'b0001);
        chk("wrap_grant", 32'(grant_idx), 32'd0);
        complete(1'b0);
        issue(4'b0011);
        chk("ptr1_grant", 32'(grant_idx), 32'd1);
        complete(1'b0);

        // Full contention from a fresh pointer.
        do_reset();
        req_in = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            issue(req_in);
            chk("rotation", 32'(grant_idx), 32'(order[i]));
            complete(1'b1);
        end
        req_in = '0;
        tick();

        // Non-granted bit toggling during ACK has no effect.
        issue(4'b0100);
        ack_out = 1'b1;
        tick();
        req_in[0] = 1'b1;
        tick();
        chk("ng_ack_in_a", 32'(ack_in), 32'b0100);
        req_in[0] = 1'b0;
        tick();
        chk("ng_ack_in_b", 32'(ack_in), 32'b0100);
        req_in[0] = 1'b1;
        req_in[2] = 1'b0;
        tick();
        chk("ng_req_out", 32'(req_out), 32'd0);
        ack_out = 1'b0;
        tick();
        chk("ng_idle", 32'(ack_in), 32'd0);
        m_ptr = 3;
        issue(4'b0001);
        chk("ng_next_grant", 32'(grant_idx), 32'd0);
        complete(1'b0);

        // ack_out stuck high in IDLE blocks new grants.
        ack_out = 1'b1;
        req_in  = 4'b0010;
        tick();
        tick();
        chk("ackidle_block", 32'(req_out), 32'd0);
        chk("ackidle_busy", 32'(busy), 32'd0);
        ack_out = 1'b0;
        issue(4'b0010);
        complete(1'b0);

        // Asynchronous reset during ACK.
        issue(4'b0100);
        ack_out = 1'b1;
        tick();
        chk("pre_rst_ack", 32'(ack_in), 32'b0100);
        #2 rst_n = 1'b0;
        #1;
        chk("async_ack_in", 32'(ack_in), 32'd0);
        chk("async_req_out", 32'(req_out), 32'd0);
        chk("async_busy", 32'(busy), 32'd0);
        chk("async_grant", 32'(grant_idx), 32'd0);
        ack_out = 1'b0;
        req_in  = '0;
        m_ptr   = 0;
        tick();
        rst_n = 1'b1;
        tick();
        issue(4'b0100);
        chk("post_rst_grant", 32'(grant_idx), 32'd2);
        complete(1'b0);

        chk("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
